// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_pkg
// Description : Shared state encoding, start code and helpers for the
//               iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    typedef logic [1:0] md_state_t;

    localparam md_state_t c_st_idle = 2'd0;
    localparam md_state_t c_st_run  = 2'd1;
    localparam md_state_t c_st_fix  = 2'd2;
    localparam md_state_t c_st_done = 2'd3;

    localparam logic [1:0] MD_START = 2'b01;
    localparam int         MD_ITER  = 32;

    // Magnitude of a two's-complement word; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? -v : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_negate64.sv
`default_nettype none
// ============================================================================
// Module      : md_negate64
// Description : Conditional two's-complement negate used when signs are
//               applied to multiply and divide results.
// Revision    : 1.0 - initial release
// ============================================================================
module md_negate64 #(
    parameter int WIDTH = 64
) (
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    assign o_dout = i_neg ? -i_din : i_din;

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative signed multiply (shift-add) and restoring divide,
//               one bit per cycle, with results held in HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clck,
    input  logic             reset,
    input  logic [1:0]       MulCtrl,
    input  logic [1:0]       DivCtrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             busy,
    output logic             done,
    output logic             DivZero
);

    localparam int c_cnt_w = $clog2(MD_ITER);

    md_state_t          r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_is_div;
    logic               r_sign_q;
    logic               r_sign_r;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opd;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_div_zero;

    logic               w_mul_go;
    logic               w_div_go;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_rem_ext;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_rem_new;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_neg_main_in;
    logic [2*WIDTH-1:0] w_neg_main;
    logic [WIDTH-1:0]   w_neg_rem;

    // Multiply takes priority when both start codes arrive together.
    assign w_mul_go = (MulCtrl == MD_START);
    assign w_div_go = (DivCtrl == MD_START) && !w_mul_go;
    assign w_abs_a  = abs32(A);
    assign w_abs_b  = abs32(B);

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_opd} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend bits shifting into quotient}.
    assign w_div_rem_ext = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff    = w_div_rem_ext - {1'b0, r_opd};
    assign w_div_ge      = !w_div_diff[WIDTH];
    assign w_div_rem_new = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_rem_ext[WIDTH-1:0];
    assign w_div_next    = {w_div_rem_new, r_acc[WIDTH-2:0], w_div_ge};

    assign w_neg_main_in = r_is_div ? {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]} : r_acc;

    md_negate64 #(
        .WIDTH (2*WIDTH)
    ) u_neg_main (
        .i_neg  (r_sign_q),
        .i_din  (w_neg_main_in),
        .o_dout (w_neg_main)
    );

    md_negate64 #(
        .WIDTH (WIDTH)
    ) u_neg_rem (
        .i_neg  (r_sign_r),
        .i_din  (r_acc[2*WIDTH-1:WIDTH]),
        .o_dout (w_neg_rem)
    );

    always_ff @(posedge clck or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_acc      <= '0;
            r_opd      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_mul_go || w_div_go) begin
                        r_div_zero <= 1'b0;
                        if (w_div_go && (B == '0)) begin
                            r_div_zero <= 1'b1;
                            r_state    <= c_st_done;
                        end else begin
                            r_is_div <= w_div_go;
                            r_sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
                            r_sign_r <= A[WIDTH-1];
                            r_opd    <= w_div_go ? w_abs_b : w_abs_a;
                            r_acc    <= {{WIDTH{1'b0}}, (w_div_go ? w_abs_a : w_abs_b)};
                            r_cnt    <= c_cnt_w'(MD_ITER - 1);
                            r_state  <= c_st_run;
                        end
                    end
                end
                c_st_run: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    if (r_cnt == '0) begin
                        r_state <= c_st_fix;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_st_fix: begin
                    if (r_is_div) begin
                        r_lo <= w_neg_main[WIDTH-1:0];
                        r_hi <= w_neg_rem;
                    end else begin
                        r_lo <= w_neg_main[WIDTH-1:0];
                        r_hi <= w_neg_main[2*WIDTH-1:WIDTH];
                    end
                    r_state <= c_st_done;
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign Hi      = r_hi;
    assign Lo      = r_lo;
    assign busy    = (r_state == c_st_run) || (r_state == c_st_fix);
    assign done    = (r_state == c_st_done);
    assign DivZero = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Scoreboard bench for mult_div_unit with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        string       name;
    } exp_t;

    logic        clck;
    logic        reset;
    logic [1:0]  MulCtrl;
    logic [1:0]  DivCtrl;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        busy;
    logic        done;
    logic        DivZero;

    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   start_cyc  = 0;
    int   done_seen  = 0;
    exp_t sb_q[$];

    mult_div_unit #(
        .WIDTH (32)
    ) dut (
        .clck    (clck),
        .reset   (reset),
        .MulCtrl (MulCtrl),
        .DivCtrl (DivCtrl),
        .A       (A),
        .B       (B),
        .Hi      (Hi),
        .Lo      (Lo),
        .busy    (busy),
        .done    (done),
        .DivZero (DivZero)
    );

    initial clck = 1'b0;
    always #5 clck = ~clck;

    always @(posedge clck) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic expect_result(input string name, input logic [31:0] hi,
                                 input logic [31:0] lo, input logic dz);
        exp_t e;
        e.hi   = hi;
        e.lo   = lo;
        e.dz   = dz;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clck) begin
        if (!reset && done) begin
            exp_t e;
            done_seen++;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no done (Lo=0x%08h)", Lo);
            end else begin
                e = sb_q.pop_front();
                check32({e.name, "_hi"}, Hi, e.hi);
                check32({e.name, "_lo"}, Lo, e.lo);
                check1({e.name, "_divzero"}, DivZero, e.dz);
            end
        end
    end

    // Drive a start for one cycle; operands are scrambled right after the
    // sampling edge so results must come from the captured values.
    task automatic start_op(input logic [1:0] mc, input logic [1:0] dc,
                            input logic [31:0] a, input logic [31:0] b);
        @(negedge clck);
        MulCtrl = mc;
        DivCtrl = dc;
        A       = a;
        B       = b;
        @(posedge clck);
        #1;
        start_cyc = cyc;
        MulCtrl   = 2'b00;
        DivCtrl   = 2'b00;
        A         = ~a ^ 32'h5a5a_1234;
        B         = b + 32'h0000_0013;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        bit busy_ok;
        busy_ok = 1'b1;
        while (!done && (cyc - start_cyc) < 60) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clck);
            #1;
        end
        check32({name, "_latency"}, 32'(cyc - start_cyc), 32'(exp_lat));
        if (exp_lat > 0) check1({name, "_busy_during"}, busy_ok, 1'b1);
        check1({name, "_busy_at_done"}, busy, 1'b0);
        @(posedge clck);
        #1;
        check1({name, "_done_one_cycle"}, done, 1'b0);
    endtask

    task automatic run_op(input string name, input logic [1:0] mc, input logic [1:0] dc,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo,
                          input logic dz, input int lat);
        expect_result(name, hi, lo, dz);
        start_op(mc, dc, a, b);
        wait_done(name, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int snap;
        reset   = 1'b1;
        MulCtrl = 2'b00;
        DivCtrl = 2'b00;
        A       = '0;
        B       = '0;
        #1;
        check32("reset_hi", Hi, 32'h0);
        check32("reset_lo", Lo, 32'h0);
        check1("reset_busy", busy, 1'b0);
        check1("reset_done", done, 1'b0);
        check1("reset_divzero", DivZero, 1'b0);
        repeat (2) @(negedge clck);
        reset = 1'b0;

        run_op("mul_7_m3",    2'b01, 2'b00, 32'h7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33);
        run_op("mul_m1_m1",   2'b01, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,        32'h1,        1'b0, 33);
        run_op("mul_min_min", 2'b01, 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,       1'b0, 33);
        run_op("div_m7_2",    2'b00, 2'b01, 32'hFFFF_FFF9, 32'h2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
        run_op("div_min_m1",  2'b00, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 1'b0, 33);
        run_op("div_preset",  2'b00, 2'b01, 32'h2211,     32'h100,      32'h11,       32'h22,       1'b0, 33);

        run_op("div_zero",    2'b00, 2'b01, 32'h5,        32'h0,        32'h11,       32'h22,       1'b1, 0);
        check1("divzero_sticky", DivZero, 1'b1);
        check32("divzero_hi_kept", Hi, 32'h11);

        expect_result("mul_after_dz", 32'h0, 32'd12, 1'b0);
        start_op(2'b01, 2'b00, 32'd3, 32'd4);
        check1("divzero_cleared_on_start", DivZero, 1'b0);
        wait_done("mul_after_dz", 33);

        run_op("div_100_7",   2'b00, 2'b01, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33);
        run_op("both_start",  2'b01, 2'b01, 32'd6,        32'd7,        32'h0,        32'd42,       1'b0, 33);

        // A divide-by-zero start at edge 10 of a running multiply is ignored.
        expect_result("ignore_mid", 32'h0, 32'd25, 1'b0);
        start_op(2'b01, 2'b00, 32'd5, 32'd5);
        repeat (9) @(posedge clck);
        @(negedge clck);
        DivCtrl = 2'b01;
        A       = 32'd9;
        B       = 32'd0;
        @(posedge clck);
        #1;
        DivCtrl = 2'b00;
        check1("ignore_mid_busy", busy, 1'b1);
        wait_done("ignore_mid", 33);

        // Reset just after edge 15 of a multiply aborts it silently.
        start_op(2'b01, 2'b00, 32'd1234, 32'd5);
        repeat (15) @(posedge clck);
        #2;
        reset = 1'b1;
        #1;
        check32("midreset_hi", Hi, 32'h0);
        check32("midreset_lo", Lo, 32'h0);
        check1("midreset_busy", busy, 1'b0);
        check1("midreset_done", done, 1'b0);
        check1("midreset_divzero", DivZero, 1'b0);
        repeat (2) @(negedge clck);
        reset = 1'b0;
        snap = done_seen;
        repeat (40) @(posedge clck);
        #1;
        check32("midreset_no_done", 32'(done_seen - snap), 32'h0);
        check1("midreset_idle", busy, 1'b0);

        run_op("mul_m2_3",    2'b01, 2'b00, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 33);

        repeat (3) @(posedge clck);
        check32("scoreboard_empty", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative signed multiply/divide unit downstream of the multicycle control state machine; executes MIPS mult/div and holds the results in HI/LO.
- Control drives MulCtrl/DivCtrl; the A and B registers drive the operands.
- The control FSM waits on busy/done; DivZero feeds the exception path.
- An mfhi/mflo read uses Hi/Lo through the MemToReg mux.

Parameters:
- WIDTH, 32, operand and result width. Only 32 is verified.

Ports:
- clck  in  1  system clock; rising edge
- reset  in  1  asynchronous, active-high
- MulCtrl  in  2  2'b01 = start signed multiply; all other codes = no-op
- DivCtrl  in  2  2'b01 = start signed divide; all other codes = no-op
- A  in  WIDTH  operand: multiplicand or dividend
- B  in  WIDTH  operand: multiplier or divisor
- Hi  out  WIDTH  multiply: product[63:32]; divide: remainder
- Lo  out  WIDTH  multiply: product[31:0]; divide: quotient
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle completion strobe
- DivZero  out  1  last divide had B==0; sticky until the next accepted start

Behaviour:
- Reset (async): state=IDLE; Hi=0, Lo=0, busy=0, done=0, DivZero=0; counter and work registers cleared. A reset mid-operation aborts the operation and produces no done.
- States: IDLE, RUN, FIX, DONE. Outputs are Moore: busy = (RUN|FIX), done = DONE.
- Edge 0, IDLE with a start code present:
  - Capture |A|, |B|, sign_q = A[31]^B[31], sign_r = A[31], and op (mul/div).
  - Clear DivZero. Counter = 31. Go to RUN.
  - Operand changes after edge 0 are ignored.
- Simultaneous starts: if MulCtrl and DivCtrl both request start, multiply wins.
- Start codes seen in RUN, FIX or DONE are ignored; no queueing.
- Divide by zero: DivCtrl start with B==0 goes IDLE->DONE at edge 0 with DivZero=1; Hi/Lo are unchanged.
- RUN, multiply: unsigned shift-add, one bit per cycle over a 64-bit accumulator.
- RUN, divide: restoring divide, one quotient bit per cycle, 32-bit remainder register.
- RUN counting: edges 1..32 iterate; at counter==0 go to FIX, otherwise decrement.
- FIX (edge 33): apply signs and write Hi/Lo, then go to DONE.
  - Multiply: {Hi,Lo} = sign_q ? -prod : prod (64-bit two's complement).
  - Divide: Lo = sign_q ? -q : q; Hi = sign_r ? -r : r (quotient truncates toward zero; remainder takes the dividend's sign).
  - 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0 (32-bit wrap); no flag is raised.
- DONE: done=1 for exactly one cycle, then IDLE at the next edge. A start can be accepted on the edge that leaves DONE only if state is already IDLE, so the earliest restart is the cycle after done.
- Latency: done is visible in the cycle after edge 33 (34 cycles from sample to done). The divide-by-zero path takes 1 cycle.
- Hi/Lo change only in FIX or on reset. They hold their values otherwise, including during busy.

Decomposition:
- Shared package md_pkg:
  - state enum {IDLE, RUN, FIX, DONE}
  - MD_START = 2'b01
  - MD_ITER = 32
  - helper function abs32
- Optional sub-module md_negate64: conditional two's-complement negate used by FIX for both mul and div. Everything else stays in this module.

Test Plan:
- Mul: A=7, B=0xFFFFFFFD (-3) -> after 34 cycles done=1, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; busy high edges 1..33.
- Mul: A=B=0xFFFFFFFF -> Hi=0, Lo=1. Then A=0x80000000, B=0x80000000 -> Hi=0x40000000, Lo=0.
- Div: A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF, DivZero=0.
- Div: A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Div by zero: prior Hi/Lo=0x11/0x22, A=5, B=0 -> done in the cycle after edge 0, DivZero=1, Hi/Lo still 0x11/0x22. The next mul start clears DivZero.
- Robustness:
  - Change A/B during RUN: the result uses the captured operands.
  - MulCtrl and DivCtrl both 01: a multiply result is produced.
  - Start pulse at edge 10 of a busy op is ignored.
  - Reset at edge 15: all outputs are 0 immediately and no done follows.
